hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 46 ++++
 rtl/hazard_if.sv | 41 ++++
 rtl/hazard_tag_pipe.sv | 28 ++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
// Tag fields are sized by TAG_REG_W, which must match the REG_W used on the ports.
package hazard_pkg;

    localparam int TAG_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        FREEZE,
        FLUSH_PEND
    } hz_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_REG_W-1:0] rd;
        logic                 is_load;
        logic [TAG_REG_W-1:0] rs1;
        logic [TAG_REG_W-1:0] rs2;
        logic                 uses_rs1;
        logic                 uses_rs2;
    } tag_t;

    // near is the producer moving into EX/MEM and wins over far (moving into MEM/WB)
    function automatic fwd_sel_t fwd_pick(
        input logic                 reads,
        input logic [TAG_REG_W-1:0] rs,
        input tag_t                 near,
        input tag_t                 far
    );
        if (!reads || rs == '0)
            return FWD_RF;
        if (near.valid && near.rd == rs)
            return FWD_EXMEM;
        if (far.valid && far.rd == rs)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: ID-stage hazard inputs and pipeline control outputs of hazard_ctrl.
// The core side uses master, the controller uses slave.
interface hazard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_writes_rd;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             stall_pc;
    logic             stall_if_id;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             freeze_all;
    logic [1:0]       f_rs1;
    logic [1:0]       f_rs2;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, ex_branch_taken, mem_busy,
        input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze_all,
               f_rs1, f_rs2, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, ex_branch_taken, mem_busy,
        output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze_all,
               f_rs1, f_rs2, stall_cycles
    );

endinterface

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: EX/MEM/WB destination-tag shift register.
// hold freezes all three entries; bubble loads an invalid tag into EX.
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic bubble,
    input  tag_t id_tag,
    output tag_t ex_t,
    output tag_t mem_t,
    output tag_t wb_t
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_t  <= '0;
            mem_t <= '0;
            wb_t  <= '0;
        end else if (!hold) begin
            wb_t  <= mem_t;
            mem_t <= ex_t;
            ex_t  <= bubble ? '0 : id_tag;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush, memory-wait freeze and
// registered forward selects for the five-stage integer core.
//
// state      | meaning
// RUN        | normal issue, no hazard pending
// LD_STALL   | previous cycle inserted a load-use bubble
// FREEZE     | memory busy, whole pipe held
// FLUSH_PEND | branch seen during freeze, flush due when memory releases
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);

    tag_t             id_tag;
    tag_t             ex_t;
    tag_t             mem_t;
    tag_t             wb_t;
    logic [REG_W-1:0] ex_rd;

    hz_state_t        state;
    hz_state_t        state_nx;
    hz_state_t        saved;
    hz_state_t        saved_nx;
    hz_state_t        cur;

    logic             rst_q;
    logic             gate;
    logic             load_use;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             freeze;

    fwd_sel_t         f_rs1_q;
    fwd_sel_t         f_rs2_q;
    logic [CNT_W-1:0] cnt;

    logic             unused_tag_bits;

    always_comb begin
        id_tag          = '0;
        id_tag.valid    = hz.id_valid && hz.id_writes_rd && (hz.id_rd != '0);
        id_tag.rd       = hz.id_rd;
        id_tag.is_load  = hz.id_is_load;
        id_tag.rs1      = hz.id_rs1;
        id_tag.rs2      = hz.id_rs2;
        id_tag.uses_rs1 = hz.id_uses_rs1;
        id_tag.uses_rs2 = hz.id_uses_rs2;
    end

    hazard_tag_pipe u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .hold   (freeze),
        .bubble (bubble),
        .id_tag (id_tag),
        .ex_t   (ex_t),
        .mem_t  (mem_t),
        .wb_t   (wb_t)
    );

    assign ex_rd = ex_t.rd;

    assign load_use = ex_t.valid && ex_t.is_load && hz.id_valid &&
                      ((hz.id_uses_rs1 && hz.id_rs1 == ex_rd) ||
                       (hz.id_uses_rs2 && hz.id_rs2 == ex_rd));

    // Hazard outputs stay quiet on the reset cycle and the one after it.
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    assign gate = reset || rst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            saved <= RUN;
        end else begin
            state <= state_nx;
            saved <= saved_nx;
        end
    end

    // saved is the resume state; it doubles as the latch for a branch seen while frozen.
    always_comb begin
        state_nx = state;
        saved_nx = saved;
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        freeze   = 1'b0;
        cur      = (state == FREEZE) ? saved : state;

        if (gate) begin
            state_nx = RUN;
        end else if (hz.mem_busy) begin
            freeze   = 1'b1;
            state_nx = FREEZE;
            if (state != FREEZE)
                saved_nx = state;
            if (hz.ex_branch_taken)
                saved_nx = FLUSH_PEND;
        end else if (cur == FLUSH_PEND || hz.ex_branch_taken) begin
            flush    = 1'b1;
            bubble   = 1'b1;
            state_nx = RUN;
        end else if (load_use) begin
            stall    = 1'b1;
            bubble   = 1'b1;
            state_nx = LD_STALL;
        end else begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_rs1_q <= FWD_RF;
            f_rs2_q <= FWD_RF;
        end else if (!freeze) begin
            if (bubble) begin
                f_rs1_q <= FWD_RF;
                f_rs2_q <= FWD_RF;
            end else begin
                f_rs1_q <= fwd_pick(hz.id_valid && hz.id_uses_rs1, hz.id_rs1, ex_t, mem_t);
                f_rs2_q <= fwd_pick(hz.id_valid && hz.id_uses_rs2, hz.id_rs2, ex_t, mem_t);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if ((stall || bubble || freeze) && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    // WB and source fields are carried for pipeline visibility only.
    assign unused_tag_bits = ^{wb_t, ex_t.rs1, ex_t.rs2, ex_t.uses_rs1, ex_t.uses_rs2,
                               mem_t.is_load, mem_t.rs1, mem_t.rs2,
                               mem_t.uses_rs1, mem_t.uses_rs2};

    assign hz.stall_pc     = stall;
    assign hz.stall_if_id  = stall;
    assign hz.bubble_id_ex = bubble;
    assign hz.flush_if_id  = flush;
    assign hz.freeze_all   = freeze;
    assign hz.f_rs1        = f_rs1_q;
    assign hz.f_rs2        = f_rs2_q;
    assign hz.stall_cycles = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan steps followed by random traffic, checked
// against an instruction-level model of the pipeline hazard rules.
module tb_hazard_ctrl;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       w;
        logic       ld;
    } ins_t;

    // d is the register the instruction will write, 0 when it writes nothing
    typedef struct {
        logic [4:0] d;
        logic       ld;
    } stg_t;

    logic clk = 1'b0;
    logic reset;

    hazard_if #(.REG_W(5), .CNT_W(CW)) hz();

    hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    stg_t       m_ex;
    stg_t       m_mem;
    logic [1:0] m_f1;
    logic [1:0] m_f2;
    int         m_cnt;
    logic       m_pend;
    logic       m_warm;

    logic last_stall, last_bubble, last_flush, last_freeze;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic w, input logic ld);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.w = w; i.ld = ld;
        return i;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic v, input logic u, input logic [4:0] s);
        if (!v || !u || s == '0) return 2'b00;
        if (m_ex.d == s)         return 2'b01;
        if (m_mem.d == s)        return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input ins_t i, input logic br, input logic busy);
        hz.id_valid        = i.v;
        hz.id_rs1          = i.rs1;
        hz.id_rs2          = i.rs2;
        hz.id_uses_rs1     = i.u1;
        hz.id_uses_rs2     = i.u2;
        hz.id_rd           = i.rd;
        hz.id_writes_rd    = i.w;
        hz.id_is_load      = i.ld;
        hz.ex_branch_taken = br;
        hz.mem_busy        = busy;
    endtask

    task automatic model_reset();
        m_ex.d = '0;  m_ex.ld = 1'b0;
        m_mem.d = '0; m_mem.ld = 1'b0;
        m_f1 = 2'b00; m_f2 = 2'b00;
        m_cnt = 0; m_pend = 1'b0; m_warm = 1'b0;
    endtask

    task automatic do_reset(input logic busy, input logic br);
        ins_t idle;
        idle = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(idle, br, busy);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_stall_pc",    32'(hz.stall_pc),     32'd0);
        chk("rst_bubble",      32'(hz.bubble_id_ex), 32'd0);
        chk("rst_flush",       32'(hz.flush_if_id),  32'd0);
        chk("rst_freeze",      32'(hz.freeze_all),   32'd0);
        @(posedge clk);
        #1;
        chk("rst_f_rs1",        32'(hz.f_rs1),        32'd0);
        chk("rst_f_rs2",        32'(hz.f_rs2),        32'd0);
        chk("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input ins_t i, input logic br, input logic busy);
        logic e_frz, e_fl, e_st, e_bub;
        drive(i, br, busy);
        e_frz = 1'b0; e_fl = 1'b0; e_st = 1'b0; e_bub = 1'b0;
        if (m_warm) begin
            if (busy) begin
                e_frz = 1'b1;
            end else if (br || m_pend) begin
                e_fl = 1'b1; e_bub = 1'b1;
            end else if (i.v && m_ex.ld && m_ex.d != '0 &&
                         ((i.u1 && i.rs1 == m_ex.d) || (i.u2 && i.rs2 == m_ex.d))) begin
                e_st = 1'b1; e_bub = 1'b1;
            end
        end
        @(negedge clk);
        chk("stall_pc",     32'(hz.stall_pc),     32'(e_st));
        chk("stall_if_id",  32'(hz.stall_if_id),  32'(e_st));
        chk("bubble_id_ex", 32'(hz.bubble_id_ex), 32'(e_bub));
        chk("flush_if_id",  32'(hz.flush_if_id),  32'(e_fl));
        chk("freeze_all",   32'(hz.freeze_all),   32'(e_frz));
        chk("f_rs1",        32'(hz.f_rs1),        32'(m_f1));
        chk("f_rs2",        32'(hz.f_rs2),        32'(m_f2));
        chk("stall_cycles", 32'(hz.stall_cycles), m_cnt);
        last_stall  = hz.stall_pc;
        last_bubble = hz.bubble_id_ex;
        last_flush  = hz.flush_if_id;
        last_freeze = hz.freeze_all;
        @(posedge clk);
        if (e_frz) begin
            m_pend = m_pend | br;
        end else begin
            m_pend = 1'b0;
            if (e_bub) begin
                m_f1 = 2'b00; m_f2 = 2'b00;
            end else begin
                m_f1 = exp_fwd(i.v, i.u1, i.rs1);
                m_f2 = exp_fwd(i.v, i.u2, i.rs2);
            end
            m_mem = m_ex;
            m_ex.d  = (!e_bub && i.v && i.w) ? i.rd : 5'd0;
            m_ex.ld = i.ld;
        end
        if ((e_frz || e_bub) && m_cnt < CMAX) m_cnt++;
        m_warm = 1'b1;
        #1;
    endtask

    initial begin
        ins_t nop, cur;
        nop = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        last_stall = 1'b0; last_bubble = 1'b0; last_flush = 1'b0; last_freeze = 1'b0;
        model_reset();

        // add x1 ; add x2,x1,x1
        do_reset(1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_exmem_rs1", 32'(hz.f_rs1), 32'd1);
        chk("tp_exmem_rs2", 32'(hz.f_rs2), 32'd1);
        chk("tp_exmem_nostall", 32'(last_stall), 32'd0);

        // add x3 ; nop ; sub x4,x3,x0
        cycle(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_memwb_rs1", 32'(hz.f_rs1), 32'd2);
        chk("tp_memwb_rs2", 32'(hz.f_rs2), 32'd0);

        // lw x5 ; add x6,x5,x0, then a second back-to-back pair
        do_reset(1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_lu_stall",  32'(last_stall),  32'd1);
        chk("tp_lu_bubble", 32'(last_bubble), 32'd1);
        cycle(mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_lu_release", 32'(last_stall),      32'd0);
        chk("tp_lu_fwd",     32'(hz.f_rs1),        32'd2);
        chk("tp_lu_count",   32'(hz.stall_cycles), 32'd1);
        cycle(mk(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_b2b_count", 32'(hz.stall_cycles), 32'd2);
        chk("tp_b2b_fwd",   32'(hz.f_rs2),        32'd2);

        // add x0 ; add x1,x0,x0
        cycle(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("tp_x0_rs1", 32'(hz.f_rs1), 32'd0);
        chk("tp_x0_rs2", 32'(hz.f_rs2), 32'd0);

        // taken branch over a lw/use pair
        cycle(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1), 1'b0, 1'b0);
        cycle(mk(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0), 1'b1, 1'b0);
        chk("tp_br_flush",  32'(last_flush),  32'd1);
        chk("tp_br_bubble", 32'(last_bubble), 32'd1);
        chk("tp_br_nostall", 32'(last_stall), 32'd0);
        cycle(nop, 1'b0, 1'b0);

        // 3-cycle freeze with branch in the first cycle
        do_reset(1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        cycle(nop, 1'b1, 1'b1);
        cycle(nop, 1'b0, 1'b1);
        cycle(nop, 1'b0, 1'b1);
        chk("tp_frz_on", 32'(last_freeze), 32'd1);
        cycle(nop, 1'b0, 1'b0);
        chk("tp_frz_flush", 32'(last_flush),      32'd1);
        chk("tp_frz_count", 32'(hz.stall_cycles), 32'd4);
        cycle(nop, 1'b0, 1'b0);
        chk("tp_frz_single_flush", 32'(last_flush), 32'd0);

        // reset during freeze drops the pending flush
        cycle(nop, 1'b1, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle(nop, 1'b1, 1'b1);
        chk("tp_post_rst_freeze", 32'(last_freeze), 32'd0);
        cycle(nop, 1'b0, 1'b0);
        chk("tp_post_rst_noflush", 32'(last_flush), 32'd0);

        // counter saturation
        do_reset(1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        repeat (CMAX + 5) cycle(nop, 1'b0, 1'b1);
        chk("tp_saturate", 32'(hz.stall_cycles), CMAX);

        // random traffic; ID holds while stalled or frozen
        do_reset(1'b0, 1'b0);
        cur = nop;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
                last_stall = 1'b0;
                last_freeze = 1'b0;
            end
            if (!(last_stall || last_freeze)) begin
                cur.v   = $urandom_range(0, 3) != 0;
                cur.rs1 = 5'($urandom_range(0, 7));
                cur.rs2 = 5'($urandom_range(0, 7));
                cur.u1  = $urandom_range(0, 3) != 0;
                cur.u2  = $urandom_range(0, 1) != 0;
                cur.rd  = 5'($urandom_range(0, 7));
                cur.w   = $urandom_range(0, 4) != 0;
                cur.ld  = $urandom_range(0, 2) == 0;
            end
            cycle(cur, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
